// File: rtl/instruction_loader_if.sv
// Host/memory bus of the instruction loader.
// The host drives load requests and the byte stream; the loader drives the memory write port.
interface instruction_loader_if;
    logic [31:0] initial_address;
    logic        load_start;
    logic [10:0] load_word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        core_hold;
    logic        load_done;
    logic        load_error;

    modport master (
        output initial_address,
        output load_start,
        output load_word_count,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_write_enable,
        input  mem_write_address,
        input  mem_write_data,
        input  core_hold,
        input  load_done,
        input  load_error
    );

    modport slave (
        input  initial_address,
        input  load_start,
        input  load_word_count,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_write_enable,
        output mem_write_address,
        output mem_write_data,
        output core_hold,
        output load_done,
        output load_error
    );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: assembles a little-endian byte stream into
// 32-bit words and writes them to instruction memory, holding the core meanwhile.
module instruction_loader #(
    parameter int MEMORY_DEPTH = 1024,
    parameter int DATA_WIDTH   = 32
) (
    input  logic clk,
    input  logic reset,
    instruction_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned DEPTH = MEMORY_DEPTH;

    state_t                r_state, w_state;
    logic [31:0]           r_addr, w_addr;
    logic [10:0]           r_count, w_count;
    logic [10:0]           r_word, w_word;
    logic [1:0]            r_byte, w_byte;
    logic [DATA_WIDTH-1:0] r_data, w_data;
    logic                  r_hold, w_hold;
    logic                  r_done, w_done;
    logic                  r_err, w_err;
    logic                  w_bad;

    // A request is rejected if it overruns memory or is not word aligned
    assign w_bad = (32'(bus.load_word_count) > DEPTH)
                 || (bus.initial_address[1:0] != 2'b00);

    // State and datapath registers, cleared asynchronously so an abort
    // discards any partially assembled word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_word  <= '0;
            r_byte  <= '0;
            r_data  <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_count <= w_count;
            r_word  <= w_word;
            r_byte  <= w_byte;
            r_data  <= w_data;
            r_hold  <= w_hold;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    // Next-state and next-datapath logic; every register holds by default
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_count = r_count;
        w_word  = r_word;
        w_byte  = r_byte;
        w_data  = r_data;
        w_hold  = r_hold;
        w_done  = r_done;
        w_err   = r_err;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    w_done = 1'b0;
                    w_err  = 1'b0;
                    w_hold = 1'b1;
                    if (w_bad) begin
                        w_err   = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_addr  = bus.initial_address;
                        w_count = bus.load_word_count;
                        w_word  = '0;
                        w_byte  = '0;
                        if (bus.load_word_count == 11'd0) begin
                            w_state = DONE;
                            w_done  = 1'b1;
                            w_hold  = 1'b0;
                        end else begin
                            w_state = RECEIVE;
                        end
                    end
                end
            end
            RECEIVE: begin
                if (bus.byte_valid) begin
                    w_data[{r_byte, 3'b000} +: 8] = bus.byte_data;
                    w_byte = r_byte + 2'd1;
                    if (r_byte == 2'd3) begin
                        w_state = WRITE;
                    end
                end
            end
            WRITE: begin
                if (r_word + 11'd1 == r_count) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                    w_hold  = 1'b0;
                end else begin
                    w_state = RECEIVE;
                    w_byte  = '0;
                    w_word  = r_word + 11'd1;
                    w_addr  = r_addr + 32'd4;
                end
            end
        endcase
    end

    // Handshake and strobe decode straight from the registered state
    assign bus.byte_ready        = (r_state == RECEIVE);
    assign bus.mem_write_enable  = (r_state == WRITE);
    assign bus.mem_write_address = r_addr;
    assign bus.mem_write_data    = 32'(r_data);
    assign bus.core_hold         = r_hold;
    assign bus.load_done         = r_done;
    assign bus.load_error        = r_err;
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL take parameter MEMORY_DEPTH, default 1024, meaning the number of 32-bit words in the target instruction memory.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, meaning the width of an instruction word (fixed at 32; 4 bytes per word).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have port initial_address, input, 32, meaning the byte base address of the first word written; sampled on an accepted load_start.
REQ-006 The block SHALL have port load_start, input, 1, meaning a one-cycle request to begin a load.
REQ-007 The block SHALL have port load_word_count, input, 11, meaning the number of words to load; sampled with load_start.
REQ-008 The block SHALL have port byte_valid, input, 1, meaning byte_data holds a byte offered by the host.
REQ-009 The block SHALL have port byte_data, input, 8, meaning the program byte stream, little-endian within each word.
REQ-010 The block SHALL have port byte_ready, output, 1, meaning the block accepts a byte this cycle.
REQ-011 The block SHALL have port mem_write_enable, output, 1, meaning a one-cycle write strobe to the instruction memory.
REQ-012 The block SHALL have port mem_write_address, output, 32, meaning the byte address of the word being written.
REQ-013 The block SHALL have port mem_write_data, output, 32, meaning the assembled instruction word.
REQ-014 The block SHALL have port core_hold, output, 1, meaning the block holds the program counter in reset while high.
REQ-015 The block SHALL have port load_done, output, 1, meaning the last load completed successfully.
REQ-016 The block SHALL have port load_error, output, 1, meaning the last load request was rejected.

Function
REQ-017 The FSM SHALL have four states: IDLE, RECEIVE, WRITE, DONE.
REQ-018 In IDLE, DONE or after an error, load_start SHALL be accepted: it clears load_done and load_error, sets core_hold=1, latches the base address and count, clears the byte index, and moves to RECEIVE.
REQ-019 load_start SHALL be ignored in RECEIVE and WRITE.
REQ-020 If load_word_count==0 on an accepted load_start, the FSM SHALL go directly to DONE and perform no writes.
REQ-021 If load_word_count>MEMORY_DEPTH, or initial_address[1:0]!=0, on an accepted load_start, the FSM SHALL set load_error=1, stay in IDLE with core_hold=1, and perform no writes.
REQ-022 byte_ready SHALL be 1 only in RECEIVE; a byte transfers on a rising edge with byte_valid && byte_ready.
REQ-023 Transferred byte k (0..3) of a word SHALL land in mem_write_data bits [8k+7:8k].
REQ-024 After the 4th byte transfers, the FSM SHALL enter WRITE for exactly one cycle with mem_write_enable=1, holding byte_ready=0.
REQ-025 The word index n (0-based) SHALL be written at mem_write_address = base + 4*n, modulo 2^32.
REQ-026 After WRITE, the FSM SHALL go to DONE if n+1 == count, else back to RECEIVE with the byte index cleared.
REQ-027 In DONE, load_done SHALL be 1 and core_hold 0 until the next accepted load_start.
REQ-028 byte_valid deasserted mid-word SHALL stall assembly without losing accepted bytes, for any number of cycles.
REQ-029 mem_write_enable SHALL be 0 in every state except WRITE.
REQ-030 The minimum load latency SHALL be 5*count cycles from the first byte transfer to DONE, at byte_valid held high.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, byte_ready=0, mem_write_enable=0, mem_write_address=0, mem_write_data=0, core_hold=1, load_done=0, load_error=0, byte index=0, word count=0.
REQ-032 Reset asserted mid-word or during WRITE SHALL abort the load; partially assembled bytes SHALL be discarded and no further write SHALL occur.

Verification
REQ-033 Reset then load_start with count=2 and base 0x0000_0000; bytes 13,00,50,00,93,00,10,00 -> writes 0x00500013@0x0 and 0x00100093@0x4, then load_done=1, core_hold=0.
REQ-034 Base 0x0000_0100, count=1, byte_valid gapped 3 idle cycles between each byte -> single write 0x0403_0201@0x100 for bytes 01,02,03,04; no early strobe.
REQ-035 load_start with count=1025 -> load_error=1, byte_ready=0, core_hold=1, zero writes; a following valid load_start clears load_error.
REQ-036 load_start with count=0 -> DONE next cycle, load_done=1, zero writes.
REQ-037 Reset asserted after 2 bytes of word 0 -> all outputs return to reset values; a new load of count=1 writes only the new 4 bytes.
REQ-038 Base 0xFFFF_FFFC, count=2 -> writes at 0xFFFF_FFFC then 0x0000_0000 (wrap-around).
